// File: rtl/load_store_unit.sv
// load_store_unit: byte-addressed load/store front end for a word-addressed data memory,
// with sign/zero-extended loads, read-modify-write sub-word stores and misalign/range errors.
module load_store_unit #(
  parameter int N         = 32,
  parameter int MEM_DEPTH = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_we,
  input  logic [1:0]   req_size,
  input  logic         req_unsigned,
  input  logic [N-1:0] req_addr,
  input  logic [N-1:0] req_wdata,
  output logic         rsp_valid,
  output logic [N-1:0] rsp_rdata,
  output logic         rsp_err,
  output logic         mem_read,
  output logic         mem_write,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_wdata,
  input  logic [N-1:0] mem_rdata
);
  typedef enum logic [2:0] {IDLE, ACCESS, MERGE, ERR, RESP} state_t;
  localparam logic [N-3:0] DEPTH = (N-2)'(MEM_DEPTH);
  state_t state, state_nx;
  logic we_q, uns_q, err_q, sub, accept, bad;
  logic [1:0] size_q;
  logic [4:0] sh;
  logic [N-1:0] addr_q, wdata_q, merge_q, res_q, mask, merged, rd_sh, load_val;
  assign accept = req_valid & req_ready;
  assign bad = (req_size == 2'b11) | (req_size == 2'b01 & req_addr[0]) |
               (req_size == 2'b10 & |req_addr[1:0]) | (req_addr[N-1:2] >= DEPTH);
  // Lane datapath works only on captured registers, so mem_* never sees req_* directly.
  assign sub      = ~size_q[1];
  assign sh       = size_q[0] ? {addr_q[1], 4'b0} : {addr_q[1:0], 3'b0};
  assign mask     = (size_q[0] ? N'(16'hFFFF) : N'(8'hFF)) << sh;
  assign merged   = (merge_q & ~mask) | ((wdata_q << sh) & mask);
  assign rd_sh    = mem_rdata >> sh;
  assign load_val = size_q[1] ? mem_rdata :
                    size_q[0] ? {{(N-16){~uns_q & rd_sh[15]}}, rd_sh[15:0]} :
                                {{(N-8){~uns_q & rd_sh[7]}}, rd_sh[7:0]};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = accept ? (bad ? ERR : ACCESS) : IDLE;
      ACCESS:  state_nx = (we_q & sub) ? MERGE : RESP;
      MERGE:   state_nx = RESP;
      ERR:     state_nx = RESP;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    req_ready = state == IDLE;
    mem_read  = state == ACCESS & (~we_q | sub);
    mem_write = (state == ACCESS & we_q & ~sub) | state == MERGE;
    mem_addr  = {2'b0, addr_q[N-1:2]};
    mem_wdata = state == MERGE ? merged : (state == ACCESS & we_q & ~sub) ? wdata_q : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      merge_q <= '0;
      res_q   <= '0;
    end else if (accept) begin
      we_q    <= req_we;
      uns_q   <= req_unsigned;
      err_q   <= bad;
      size_q  <= req_size;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      res_q   <= '0;
    end else if (state == ACCESS) begin
      if (!we_q) res_q <= load_val;
      if (we_q & sub) merge_q <= mem_rdata;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= state == RESP;
      rsp_rdata <= state == RESP ? res_q : '0;
      rsp_err   <= state == RESP & err_q;
    end
endmodule
